// File: rtl/parity_pkg.sv
// Shared definitions for the parity frame unit.
//   state_e   : frame FSM states (IDLE, IN_FRAME)
//   PAR_MAX_W : widest word par_of() can reduce
//   par_of()  : XOR reduction of a word, inverted for odd parity
//   len_w()   : width of a counter that must hold 0..max_len
package parity_pkg;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } state_e;

  localparam int PAR_MAX_W = 64;

  // Narrower words are zero-extended by the caller; zeros do not change parity.
  function automatic logic par_of(input logic [PAR_MAX_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/parity_calc.sv
// Combinational WIDTH-bit parity with odd/even select.
//   data : word to reduce (WIDTH <= PAR_MAX_W)
//   odd  : 1 inverts the result (odd parity, or XOR-in of a running value)
//   par  : ^data ^ odd
module parity_calc
  import parity_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic             odd,
  output logic             par
);

  logic [PAR_MAX_W-1:0] data_ext_s;

  assign data_ext_s = PAR_MAX_W'(data);
  assign par        = par_of(data_ext_s, odd);

endmodule

// File: rtl/parity_frame_unit.sv
// Streaming parity generator/checker with frame parity, MAX_LEN truncation
// and a saturating word-error counter.
//   clk, rst_n              : clock, asynchronous active-low reset
//   mode_odd, mode_check    : parity sense / check enable, latched on a frame's first word
//   clr_cnt                 : synchronous clear of err_cnt (wins over an increment)
//   in_valid/in_ready       : input handshake for in_data, in_par, in_last
//   out_valid/out_ready     : output handshake for the single registered output word
//   out_data, out_par       : word and its generated parity
//   out_err                 : word parity mismatch (check mode only)
//   out_last, out_trunc     : frame end, and whether it was forced by MAX_LEN
//   out_frame_par           : frame parity, valid with out_last, else 0
//   err_cnt                 : saturating count of errored words
module parity_frame_unit
  import parity_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode_odd,
  input  logic             mode_check,
  input  logic             clr_cnt,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_par,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_par,
  output logic             out_err,
  output logic             out_last,
  output logic             out_trunc,
  output logic             out_frame_par,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int              LEN_W   = len_w(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

  state_e             state_r;
  state_e             state_nxt_s;
  logic               acc_r;
  logic [LEN_W-1:0]   len_r;
  logic               mode_f_r;
  logic               check_f_r;

  logic               out_valid_r;
  logic [WIDTH-1:0]   out_data_r;
  logic               out_par_r;
  logic               out_err_r;
  logic               out_last_r;
  logic               out_trunc_r;
  logic               out_frame_par_r;
  logic [CNT_W-1:0]   err_cnt_r;

  logic               in_ready_s;
  logic               accept_s;
  logic               mode_eff_s;
  logic               check_eff_s;
  logic               acc_base_s;
  logic [LEN_W-1:0]   len_nxt_s;
  logic               word_par_s;
  logic               acc_nxt_s;
  logic               at_max_s;
  logic               close_s;
  logic               trunc_s;
  logic               err_s;
  logic               frame_par_s;

  // A new word may enter whenever the output slot is empty or being drained.
  assign in_ready_s = ~out_valid_r | out_ready;
  assign accept_s   = in_valid & in_ready_s;

  // Per-word view of the frame: the first word uses the live mode inputs and
  // a cleared accumulator, later words use the latched frame state.
  always_comb begin
    mode_eff_s  = mode_f_r;
    check_eff_s = check_f_r;
    acc_base_s  = acc_r;
    len_nxt_s   = len_r + LEN_W'(1);
    if (state_r == IDLE) begin
      mode_eff_s  = mode_odd;
      check_eff_s = mode_check;
      acc_base_s  = 1'b0;
      len_nxt_s   = LEN_W'(1);
    end else begin
      mode_eff_s  = mode_f_r;
      check_eff_s = check_f_r;
      acc_base_s  = acc_r;
      len_nxt_s   = len_r + LEN_W'(1);
    end
  end

  parity_calc #(.WIDTH(WIDTH)) u_word_par (
    .data (in_data),
    .odd  (mode_eff_s),
    .par  (word_par_s)
  );

  // Accumulator update: the running value is folded in through the odd input.
  parity_calc #(.WIDTH(WIDTH)) u_acc_par (
    .data (in_data),
    .odd  (acc_base_s),
    .par  (acc_nxt_s)
  );

  assign at_max_s    = (len_nxt_s == LEN_MAX);
  assign close_s     = in_last | at_max_s;
  assign trunc_s     = at_max_s & ~in_last;
  assign err_s       = check_eff_s & (in_par ^ word_par_s);
  assign frame_par_s = acc_nxt_s ^ mode_eff_s;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: any closing word returns to IDLE, otherwise a frame is open.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE, IN_FRAME: begin
        if (accept_s) begin
          state_nxt_s = close_s ? IDLE : IN_FRAME;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Frame bookkeeping: mode latch, parity accumulator and word count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r     <= 1'b0;
      len_r     <= '0;
      mode_f_r  <= 1'b0;
      check_f_r <= 1'b0;
    end else if (accept_s) begin
      mode_f_r  <= mode_eff_s;
      check_f_r <= check_eff_s;
      if (close_s) begin
        acc_r <= 1'b0;
        len_r <= '0;
      end else begin
        acc_r <= acc_nxt_s;
        len_r <= len_nxt_s;
      end
    end
  end

  // Single output register: loads on accept, empties on downstream accept,
  // otherwise holds every field.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r     <= 1'b0;
      out_data_r      <= '0;
      out_par_r       <= 1'b0;
      out_err_r       <= 1'b0;
      out_last_r      <= 1'b0;
      out_trunc_r     <= 1'b0;
      out_frame_par_r <= 1'b0;
    end else if (accept_s) begin
      out_valid_r     <= 1'b1;
      out_data_r      <= in_data;
      out_par_r       <= word_par_s;
      out_err_r       <= err_s;
      out_last_r      <= close_s;
      out_trunc_r     <= trunc_s;
      out_frame_par_r <= close_s & frame_par_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  // Saturating error counter; a clear beats a coincident increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_r <= '0;
    end else if (clr_cnt) begin
      err_cnt_r <= '0;
    end else if (accept_s && err_s && (err_cnt_r != CNT_SAT)) begin
      err_cnt_r <= err_cnt_r + CNT_W'(1);
    end
  end

  assign in_ready      = in_ready_s;
  assign out_valid     = out_valid_r;
  assign out_data      = out_data_r;
  assign out_par       = out_par_r;
  assign out_err       = out_err_r;
  assign out_last      = out_last_r;
  assign out_trunc     = out_trunc_r;
  assign out_frame_par = out_frame_par_r;
  assign err_cnt       = err_cnt_r;

endmodule

// File: tb/tb_parity_frame_unit.sv
// Directed self-checking bench for parity_frame_unit (WIDTH=8, MAX_LEN=16, CNT_W=2).
module tb_parity_frame_unit;

  logic       clk;
  logic       rst_n;
  logic       mode_odd;
  logic       mode_check;
  logic       clr_cnt;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_par;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_par;
  logic       out_err;
  logic       out_last;
  logic       out_trunc;
  logic       out_frame_par;
  logic [1:0] err_cnt;

  int checks = 0;
  int errors = 0;

  parity_frame_unit #(.WIDTH(8), .MAX_LEN(16), .CNT_W(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mode_odd      (mode_odd),
    .mode_check    (mode_check),
    .clr_cnt       (clr_cnt),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_par        (in_par),
    .in_last       (in_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_par       (out_par),
    .out_err       (out_err),
    .out_last      (out_last),
    .out_trunc     (out_trunc),
    .out_frame_par (out_frame_par),
    .err_cnt       (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one word for one clock (in_ready is 1 whenever out_ready is 1),
  // then leave the bench #1 after the accepting edge with outputs settled.
  task automatic send(input logic [7:0] d, input logic last, input logic par,
                      input logic odd, input logic chk, input logic clr);
    in_data    = d;
    in_last    = last;
    in_par     = par;
    mode_odd   = odd;
    mode_check = chk;
    clr_cnt    = clr;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    clr_cnt  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; mode_odd = 1'b0; mode_check = 1'b0; clr_cnt = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; in_par = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    #22;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_err_cnt",   32'(err_cnt),   32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Generate mode, single-word frames.
    send(8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("gen03_valid", 32'(out_valid), 32'd1);
    check("gen03_data",  32'(out_data),  32'h03);
    check("gen03_par",   32'(out_par),   32'd0);
    send(8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("gen07_par",   32'(out_par),   32'd1);
    check("gen07_fpar",  32'(out_frame_par), 32'd1);
    send(8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("odd07_par",   32'(out_par),   32'd0);
    @(posedge clk); #1;
    check("drain_valid", 32'(out_valid), 32'd0);

    // Three-word frame; mode_odd toggled mid-frame must be ignored.
    send(8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("f1_last", 32'(out_last), 32'd0);
    check("f1_fpar", 32'(out_frame_par), 32'd0);
    send(8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("f2_par",  32'(out_par),  32'd1);
    send(8'h04, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("f3_par",  32'(out_par),  32'd1);
    check("f3_last", 32'(out_last), 32'd1);
    check("f3_fpar", 32'(out_frame_par), 32'd1);
    check("f3_trunc", 32'(out_trunc), 32'd0);

    // Check mode, even.
    send(8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("chk_err1", 32'(out_err), 32'd1);
    check("chk_cnt1", 32'(err_cnt), 32'd1);
    send(8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("chk_err0", 32'(out_err), 32'd0);
    check("chk_cnt_hold", 32'(err_cnt), 32'd1);
    @(posedge clk); #1;

    // Backpressure: A held, B waits upstream, then both delivered in order.
    out_ready = 1'b0;
    in_data = 8'h5A; in_last = 1'b1; mode_odd = 1'b0; mode_check = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_data = 8'h3D;
    check("bp_a_valid", 32'(out_valid), 32'd1);
    check("bp_a_data",  32'(out_data),  32'h5A);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("bp_a_hold", 32'(out_data), 32'h5A);
    check("bp_a_par",  32'(out_par),  32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    check("bp_b_valid", 32'(out_valid), 32'd1);
    check("bp_b_data",  32'(out_data),  32'h3D);
    check("bp_b_par",   32'(out_par),   32'd1);
    @(posedge clk); #1;
    check("bp_no_dup", 32'(out_valid), 32'd0);

    // Truncation: 16 words of 0x01, odd mode, no in_last.
    for (int i = 1; i <= 16; i++) begin
      send(8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      if (i == 15) begin
        check("tr15_last", 32'(out_last), 32'd0);
      end
    end
    check("tr16_last",  32'(out_last),  32'd1);
    check("tr16_trunc", 32'(out_trunc), 32'd1);
    check("tr16_fpar",  32'(out_frame_par), 32'd1);
    check("tr16_par",   32'(out_par),   32'd0);
    // Word 17 opens a new frame with even mode re-sampled.
    send(8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("tr17_par",   32'(out_par),   32'd1);
    check("tr17_trunc", 32'(out_trunc), 32'd0);
    check("tr17_fpar",  32'(out_frame_par), 32'd1);

    // 16-word frame ending with in_last on word 16: normal close.
    send(8'h07, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 2; i <= 16; i++) begin
      send(8'h03, (i == 16), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("l16_last",  32'(out_last),  32'd1);
    check("l16_trunc", 32'(out_trunc), 32'd0);
    check("l16_fpar",  32'(out_frame_par), 32'd1);

    // Counter saturation (starts at 1), clear priority, then recount.
    for (int i = 0; i < 5; i++) begin
      send(8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      if (i == 0) begin
        check("cnt_two", 32'(err_cnt), 32'd2);
      end
    end
    check("cnt_sat", 32'(err_cnt), 32'd3);
    send(8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    check("cnt_clr", 32'(err_cnt), 32'd0);
    check("cnt_clr_err", 32'(out_err), 32'd1);
    send(8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("cnt_after_clr", 32'(err_cnt), 32'd1);

    // Reset mid-frame, then a fresh odd-mode frame.
    for (int i = 0; i < 3; i++) begin
      send(8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rst_n = 1'b0;
    #2;
    check("mrst_valid", 32'(out_valid), 32'd0);
    check("mrst_ready", 32'(in_ready),  32'd1);
    check("mrst_data",  32'(out_data),  32'd0);
    check("mrst_cnt",   32'(err_cnt),   32'd0);
    check("mrst_last",  32'(out_last),  32'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mrst_idle", 32'(out_valid), 32'd0);
    send(8'h03, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("post_rst_par",  32'(out_par),  32'd1);
    check("post_rst_last", 32'(out_last), 32'd1);
    check("post_rst_fpar", 32'(out_frame_par), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
